// File: rtl/event_framer.sv
// ---------------------------------------------------------------------------
// event_framer
//
// Per-ADC-channel event builder in the clk_adc domain. It sits between the
// sample pipeline and the DAT_FIFO write port. Each accepted trigger rising
// edge produces one framed event in the FIFO:
//
//   HDR    {2'b11, evt_id}
//   TS_HI  {2'b10, ts[27:14]}
//   TS_LO  {2'b10, ts[13:0]}
//   SMP k  {2'b00, adc_data(T+k)}       k = 0 .. WINDOW-1
//   TRL    {2'b01, trunc, lost[12:0]}
//
// The word schedule is fixed. A word that meets fifo_full is dropped, not
// retried. Dropped words are reported in the trailer. Only the trailer waits
// for FIFO space.
//
// Parameters
//   WINDOW      samples per event, 1..4095
//   DW          ADC sample width; the frame format assumes 14
//
// Ports
//   clk_adc     in   1    ADC-recovered clock
//   RESET       in   1    asynchronous, active-low reset
//   adc_data    in   DW   pipelined ADC samples
//   trig        in   1    trigger, synchronous to clk_adc
//   arm         in   1    readout write enable; when low, new triggers are ignored
//   fifo_full   in   1    DAT_FIFO wrfull
//   fifo_data   out  16   registered word to the FIFO
//   fifo_wrreq  out  1    FIFO write strobe, never high while fifo_full=1
//   busy        out  1    a frame is in progress
//   evt_id      out  14   ID of the last accepted event
//   drop_count  out  16   rejected (armed) trigger edges, saturating
// ---------------------------------------------------------------------------
module event_framer #(
    parameter int WINDOW = 64,
    parameter int DW     = 14
) (
    input  logic          clk_adc,
    input  logic          RESET,
    input  logic [DW-1:0] adc_data,
    input  logic          trig,
    input  logic          arm,
    input  logic          fifo_full,
    output logic [15:0]   fifo_data,
    output logic          fifo_wrreq,
    output logic          busy,
    output logic [13:0]   evt_id,
    output logic [15:0]   drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TS_HI,
        S_TS_LO,
        S_SMP,
        S_TRL
    } state_t;

    localparam logic [1:0]  TAG_HDR  = 2'b11;
    localparam logic [1:0]  TAG_TS   = 2'b10;
    localparam logic [1:0]  TAG_SMP  = 2'b00;
    localparam logic [1:0]  TAG_TRL  = 2'b01;
    localparam logic [11:0] SMP_LAST = 12'(WINDOW - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_trig_q;
    logic [27:0]   r_ts_cnt;
    logic [27:0]   r_ts_lat;
    logic [DW-1:0] r_dly [3];
    logic [11:0]   r_smp_cnt;
    logic [11:0]   w_smp_cnt_nxt;
    logic          r_trunc;
    logic          w_trunc_nxt;
    logic [12:0]   r_lost;
    logic [12:0]   w_lost_nxt;
    logic [15:0]   r_fifo_data;
    logic [15:0]   w_data_nxt;
    logic          r_word_valid;
    logic          w_valid_nxt;
    logic [13:0]   r_evt_id;
    logic [13:0]   w_evt_id_nxt;
    logic [15:0]   r_drop_cnt;
    logic [15:0]   w_drop_nxt;

    logic          w_edge;
    logic          w_accept;
    logic          w_reject;
    logic          w_word_lost;
    logic          w_smp_lost;

    assign w_edge   = trig & ~r_trig_q;
    assign w_accept = w_edge & (r_state == S_IDLE) & arm & ~fifo_full;
    // Only armed edges count as rejects.
    assign w_reject = w_edge & arm & ~w_accept;

    // The word on fifo_data during this cycle is lost when the FIFO is full.
    // The word's type matches the current state, because each state shows
    // the word that the previous state registered. TRL is excluded because
    // it waits for space.
    assign w_word_lost = r_word_valid & fifo_full & (r_state != S_TRL);
    assign w_smp_lost  = w_word_lost & (r_state == S_SMP);

    // NOTE: every signal assigned in this block gets a default first. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = '0;
        w_valid_nxt   = 1'b0;
        w_smp_cnt_nxt = r_smp_cnt;
        w_evt_id_nxt  = r_evt_id;
        w_trunc_nxt   = r_trunc | w_word_lost;
        w_lost_nxt    = (w_smp_lost && (r_lost != '1)) ? r_lost + 13'd1 : r_lost;
        w_drop_nxt    = (w_reject && (r_drop_cnt != '1)) ? r_drop_cnt + 16'd1 : r_drop_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_HDR;
                    w_evt_id_nxt = r_evt_id + 14'd1;
                    w_data_nxt   = {TAG_HDR, w_evt_id_nxt};
                    w_valid_nxt  = 1'b1;
                    w_trunc_nxt  = 1'b0;
                    w_lost_nxt   = '0;
                end
            end
            S_HDR: begin
                w_state_nxt = S_TS_HI;
                w_data_nxt  = {TAG_TS, r_ts_lat[27:14]};
                w_valid_nxt = 1'b1;
            end
            S_TS_HI: begin
                w_state_nxt = S_TS_LO;
                w_data_nxt  = {TAG_TS, r_ts_lat[13:0]};
                w_valid_nxt = 1'b1;
            end
            S_TS_LO: begin
                // Sample 0 is registered here, so SMP starts with one sample
                // already issued.
                w_state_nxt   = S_SMP;
                w_smp_cnt_nxt = '0;
                w_data_nxt    = {TAG_SMP, r_dly[2]};
                w_valid_nxt   = 1'b1;
            end
            S_SMP: begin
                w_valid_nxt = 1'b1;
                if (r_smp_cnt == SMP_LAST) begin
                    // The trailer uses the next-state flags, so the loss of
                    // the last sample (visible this cycle) is included.
                    w_state_nxt = S_TRL;
                    w_data_nxt  = {TAG_TRL, w_trunc_nxt, w_lost_nxt};
                end else begin
                    w_smp_cnt_nxt = r_smp_cnt + 12'd1;
                    w_data_nxt    = {TAG_SMP, r_dly[2]};
                end
            end
            S_TRL: begin
                if (fifo_full) begin
                    w_data_nxt  = r_fifo_data;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_adc or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_trig_q     <= 1'b0;
            r_ts_cnt     <= '0;
            r_ts_lat     <= '0;
            r_smp_cnt    <= '0;
            r_trunc      <= 1'b0;
            r_lost       <= '0;
            r_fifo_data  <= '0;
            r_word_valid <= 1'b0;
            r_evt_id     <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_trig_q     <= trig;
            r_ts_cnt     <= r_ts_cnt + 28'd1;
            r_smp_cnt    <= w_smp_cnt_nxt;
            r_trunc      <= w_trunc_nxt;
            r_lost       <= w_lost_nxt;
            r_fifo_data  <= w_data_nxt;
            r_word_valid <= w_valid_nxt;
            r_evt_id     <= w_evt_id_nxt;
            r_drop_cnt   <= w_drop_nxt;
            if (w_accept) begin
                r_ts_lat <= r_ts_cnt;
            end
        end
    end

    // Sample alignment delay. Three stages here plus the fifo_data register
    // make four stages, so sample 0 equals adc_data in the trigger cycle.
    // NOTE: the delay line is reset like any other register, so the first
    // frame after reset never carries X or stale samples.
    always_ff @(posedge clk_adc or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 3; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= adc_data;
            r_dly[1] <= r_dly[0];
            r_dly[2] <= r_dly[1];
        end
    end

    assign fifo_data  = r_fifo_data;
    assign fifo_wrreq = r_word_valid & ~fifo_full;
    assign busy       = (r_state != S_IDLE);
    assign evt_id     = r_evt_id;
    assign drop_count = r_drop_cnt;

endmodule
